// File: rtl/ram16_initiator_pkg.sv
// Shared definitions for the 512x16 work-RAM initiator: RAM geometry,
// output-enable patterns and the sequencer state encoding.
package ram16_initiator_pkg;

    localparam int RAM_WORDS = 512;
    localparam int RAM_AW    = $clog2(RAM_WORDS);
    localparam int RAM_DW    = 16;

    localparam logic [RAM_DW-1:0] OE_ALL  = 16'hFFFF;
    localparam logic [RAM_DW-1:0] OE_NONE = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/ram16_rd_capture.sv
// Read-return pipe: tracks each read issue edge for two cycles, then captures
// RAM data into rdata/rvalid and flags beats whose output enables were not all set.
module ram16_rd_capture
    import ram16_initiator_pkg::*;
#(
    parameter int DW = RAM_DW
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          issue_rd,
    input  logic          clr_err,
    input  logic [DW-1:0] ram_z_in,
    input  logic [DW-1:0] ram_z_oe_in,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          rerr
);

    logic [1:0]    trk_q, trk_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          rerr_q, rerr_d;

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            trk_q    <= 2'b00;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            trk_q    <= trk_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
        end
    end

    // trk_q[1] is high on the edge two cycles after a read issue edge.
    always_comb begin
        trk_d    = {trk_q[0], issue_rd};
        rvalid_d = trk_q[1];
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        if (trk_q[1]) begin
            rdata_d = ram_z_in;
        end
        if (clr_err) begin
            rerr_d = 1'b0;
        end else if (trk_q[1] && (ram_z_oe_in != DW'(OE_ALL))) begin
            rerr_d = 1'b1;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rerr   = rerr_q;

endmodule

// File: rtl/ram16_initiator.sv
// Burst initiator for a 512x16 synchronous-read work RAM: sequences host read
// and write bursts onto registered RAM pins and returns read data as a stream.
module ram16_initiator
    import ram16_initiator_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          req,
    output logic          ack,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] wdata,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          rerr,
    output logic          busy,
    output logic          done,
    output logic          ram_cen,
    output logic          ram_rw,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_z_out,
    output logic [DW-1:0] ram_z_oe,
    input  logic [DW-1:0] ram_z_in,
    input  logic [DW-1:0] ram_z_oe_in
);

    state_e        state_q, state_d;
    logic          drain_q, drain_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ack_q, ack_d;
    logic          done_q, done_d;
    logic          cen_q, cen_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] ra_q, ra_d;
    logic [DW-1:0] zout_q, zout_d;
    logic [DW-1:0] zoe_q, zoe_d;
    logic          beat;
    logic          rd_issue;

    // A read beat issues every RUN cycle; a write beat waits for data.
    assign wdata_ready = (state_q == RUN) && wr_q;
    assign beat        = (state_q == RUN) && (!wr_q || wdata_valid);
    assign rd_issue    = beat && !wr_q;

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            cen_q   <= 1'b1;
            rw_q    <= 1'b1;
            ra_q    <= '0;
            zout_q  <= '0;
            zoe_q   <= DW'(OE_NONE);
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            cen_q   <= cen_d;
            rw_q    <= rw_d;
            ra_q    <= ra_d;
            zout_q  <= zout_d;
            zoe_q   <= zoe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) state_d = RUN;
            end
            RUN: begin
                if (beat && (cnt_q == '0)) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d  = (state_q == IDLE) && req;
        wr_d   = wr_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        cen_d  = 1'b1;
        rw_d   = 1'b1;
        ra_d   = ra_q;
        zout_d = zout_q;
        zoe_d  = DW'(OE_NONE);
        if (ack_d) begin
            wr_d   = wr;
            addr_d = addr;
            cnt_d  = len;
        end
        // Address is AW bits wide, so the increment wraps 511 -> 0 naturally.
        if (beat) begin
            cen_d  = 1'b0;
            rw_d   = !wr_q;
            ra_d   = addr_q;
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (wr_q) begin
                zout_d = wdata;
                zoe_d  = DW'(OE_ALL);
            end
        end
    end

    ram16_rd_capture #(
        .DW(DW)
    ) u_rd_capture (
        .sys_clk     (sys_clk),
        .resetl      (resetl),
        .issue_rd    (rd_issue),
        .clr_err     (ack_d),
        .ram_z_in    (ram_z_in),
        .ram_z_oe_in (ram_z_oe_in),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rerr        (rerr)
    );

    assign ack       = ack_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign ram_cen   = cen_q;
    assign ram_rw    = rw_q;
    assign ram_a     = ra_q;
    assign ram_z_out = zout_q;
    assign ram_z_oe  = zoe_q;

endmodule

// File: tb/tb_ram16_initiator.sv
// Directed bench for ram16_initiator paired with a 512x16 synchronous-read RAM
// model: a burst table plus hand-written reset and error sequences.
module tb_ram16_initiator;

    logic        sys_clk = 1'b0;
    logic        resetl;
    logic        req, ack, wr;
    logic [8:0]  addr, len;
    logic [15:0] wdata;
    logic        wdata_valid, wdata_ready;
    logic [15:0] rdata;
    logic        rvalid, rerr, busy, done;
    logic        ram_cen, ram_rw;
    logic [8:0]  ram_a;
    logic [15:0] ram_z_out, ram_z_oe, ram_z_in, ram_z_oe_in;

    int n_cmp = 0;
    int n_bad = 0;
    bit force_bad = 1'b0;

    always #5 sys_clk = ~sys_clk;

    ram16_initiator dut (
        .sys_clk     (sys_clk),
        .resetl      (resetl),
        .req         (req),
        .ack         (ack),
        .wr          (wr),
        .addr        (addr),
        .len         (len),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rerr        (rerr),
        .busy        (busy),
        .done        (done),
        .ram_cen     (ram_cen),
        .ram_rw      (ram_rw),
        .ram_a       (ram_a),
        .ram_z_out   (ram_z_out),
        .ram_z_oe    (ram_z_oe),
        .ram_z_in    (ram_z_in),
        .ram_z_oe_in (ram_z_oe_in)
    );

    // 512x16 RAM model: samples on the edge after cen goes low, registered read.
    logic [15:0] mem [0:511];
    logic [15:0] mem_dout_q = 16'h0000;
    logic [15:0] mem_oe_q   = 16'h0000;

    always @(posedge sys_clk) begin
        if (!ram_cen && ram_rw) begin
            mem_dout_q <= mem[ram_a];
            mem_oe_q   <= 16'hFFFF;
        end else begin
            if (!ram_cen && (ram_z_oe == 16'hFFFF)) mem[ram_a] <= ram_z_out;
            mem_oe_q <= 16'h0000;
        end
    end

    assign ram_z_in    = mem_dout_q;
    assign ram_z_oe_in = force_bad ? 16'h0000 : mem_oe_q;

    typedef struct {
        bit          wr;
        logic [8:0]  addr;
        logic [8:0]  len;
        logic [15:0] dbase;
        int          stall_at;
        int          stall_len;
        bit          bad;
        logic [8:0]  exp_last_a;
        int          exp_done_k;
        bit          exp_rerr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cen"},    32'(ram_cen), 32'd1);
        chk({tag, "_rw"},     32'(ram_rw), 32'd1);
        chk({tag, "_a"},      32'(ram_a), 32'd0);
        chk({tag, "_zout"},   32'(ram_z_out), 32'd0);
        chk({tag, "_zoe"},    32'(ram_z_oe), 32'd0);
        chk({tag, "_ack"},    32'(ack), 32'd0);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_done"},   32'(done), 32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_rdata"},  32'(rdata), 32'd0);
        chk({tag, "_rerr"},   32'(rerr), 32'd0);
        chk({tag, "_wready"}, 32'(wdata_ready), 32'd0);
    endtask

    task automatic run_burst(input vec_t v);
        int beats = 0;
        int rbeats = 0;
        int n;
        int last_k;
        bit exp_low, exp_rv;
        logic [8:0] exp_a;
        logic [8:0] last_a = 9'h0;
        n      = int'(v.len) + 1;
        last_k = v.exp_done_k - 2;
        force_bad = v.bad;
        @(negedge sys_clk);
        req = 1'b1; wr = v.wr; addr = v.addr; len = v.len; wdata_valid = 1'b0;
        @(posedge sys_clk); #1;
        chk("ack", 32'(ack), 32'd1);
        chk("busy_start", 32'(busy), 32'd1);
        chk("rerr_clear", 32'(rerr), 32'd0);
        req = 1'b0; wr = ~v.wr; addr = 9'h0; len = 9'h0;
        for (int k = 1; k <= v.exp_done_k + 1; k++) begin
            @(negedge sys_clk);
            wdata       = v.dbase + 16'(beats);
            wdata_valid = v.wr && !(k >= v.stall_at && k < v.stall_at + v.stall_len);
            @(posedge sys_clk); #1;
            if (k == 1) chk("ack_pulse", 32'(ack), 32'd0);
            if (v.wr) exp_low = (k <= last_k) && !(k >= v.stall_at && k < v.stall_at + v.stall_len);
            else      exp_low = (k <= n);
            exp_rv = !v.wr && (k >= 3) && (k <= n + 2);
            chk("ram_cen", 32'(ram_cen), 32'(!exp_low));
            chk("wdata_ready", 32'(wdata_ready), 32'(v.wr && (k < last_k)));
            if (ram_cen == 1'b0) begin
                exp_a = v.addr + 9'(beats);
                chk("ram_a", 32'(ram_a), 32'(exp_a));
                chk("ram_rw", 32'(ram_rw), 32'(!v.wr));
                chk("ram_z_oe", 32'(ram_z_oe), v.wr ? 32'hFFFF : 32'h0);
                if (v.wr) chk("ram_z_out", 32'(ram_z_out), 32'(v.dbase + 16'(beats)));
                last_a = ram_a;
                beats++;
            end else begin
                chk("ram_z_oe_idle", 32'(ram_z_oe), 32'h0);
            end
            chk("rvalid", 32'(rvalid), 32'(exp_rv));
            if (rvalid) begin
                chk("rdata", 32'(rdata), 32'(v.dbase + 16'(rbeats)));
                rbeats++;
            end
            chk("done", 32'(done), 32'(k == v.exp_done_k));
            chk("busy", 32'(busy), 32'(k < v.exp_done_k));
        end
        chk("beat_count", 32'(beats), 32'(n));
        chk("last_addr", 32'(last_a), 32'(v.exp_last_a));
        chk("rerr_end", 32'(rerr), 32'(v.exp_rerr));
        wdata_valid = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("rerr_sticky", 32'(rerr), 32'(v.exp_rerr));
        chk("busy_idle", 32'(busy), 32'd0);
        force_bad = 1'b0;
    endtask

    initial begin
        //          wr  addr    len  dbase     stall  bad last_a  done rerr
        vecs[0] = '{1'b1, 9'h010, 9'd3, 16'hA001, 0, 0, 1'b0, 9'h013, 6,  1'b0};
        vecs[1] = '{1'b0, 9'h010, 9'd3, 16'hA001, 0, 0, 1'b0, 9'h013, 6,  1'b0};
        vecs[2] = '{1'b1, 9'h1FE, 9'd2, 16'hB000, 0, 0, 1'b0, 9'h000, 5,  1'b0};
        vecs[3] = '{1'b0, 9'h1FE, 9'd2, 16'hB000, 0, 0, 1'b0, 9'h000, 5,  1'b0};
        vecs[4] = '{1'b1, 9'h100, 9'd5, 16'hC000, 3, 3, 1'b0, 9'h105, 11, 1'b0};
        vecs[5] = '{1'b0, 9'h100, 9'd5, 16'hC000, 0, 0, 1'b0, 9'h105, 8,  1'b0};
        vecs[6] = '{1'b0, 9'h010, 9'd0, 16'hA001, 0, 0, 1'b0, 9'h010, 3,  1'b0};
        vecs[7] = '{1'b0, 9'h010, 9'd1, 16'hA001, 0, 0, 1'b1, 9'h011, 4,  1'b1};
        vecs[8] = '{1'b0, 9'h1FE, 9'd2, 16'hB000, 0, 0, 1'b0, 9'h000, 5,  1'b0};

        resetl = 1'b0; req = 1'b0; wr = 1'b0; addr = 9'h0; len = 9'h0;
        wdata = 16'h0; wdata_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 check_reset("por");
        @(negedge sys_clk) resetl = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 9; i++) begin
            $display("burst %0d: wr=%0b addr=%h len=%0d", i, vecs[i].wr, vecs[i].addr, vecs[i].len);
            run_burst(vecs[i]);
        end

        // Reset while beat 2 of an 8-beat read is on the RAM pins.
        $display("reset mid-burst: read addr=010 len=7");
        @(negedge sys_clk);
        req = 1'b1; wr = 1'b0; addr = 9'h010; len = 9'd7;
        @(posedge sys_clk); #1;
        req = 1'b0;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        chk("mid_cen_low", 32'(ram_cen), 32'd0);
        chk("mid_a", 32'(ram_a), 32'h011);
        resetl = 1'b0;
        #1 check_reset("mid");
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk) resetl = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge sys_clk); #1;
            chk("post_rst_rvalid", 32'(rvalid), 32'd0);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_cen", 32'(ram_cen), 32'd1);
        end

        $display("recovery burst: read addr=010 len=3");
        run_burst(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram16_initiator.md
# ram16_initiator

Bus initiator for the 512×16 single-port, synchronous-read work RAMs used throughout the design. Those RAMs have an active-low chip enable, `rw` (1 = read), a 9-bit address, and a registered read path with per-bit output enables. The block accepts burst requests from a host engine (blitter-/DSP-style client) and sequences them onto the RAM pins. Write beats are paced by a write-data handshake. Read data is returned as a qualified stream with fixed latency.

## Interface
Parameters:
- `AW`, 9: RAM address width (word addresses 0–511).
- `DW`, 16: data width.

Ports:
- `sys_clk` in 1: sole clock; all state changes on the rising edge.
- `resetl` in 1: asynchronous, active-low reset.
- `req` in 1: level request; sampled only in IDLE.
- `ack` out 1: one-cycle pulse; request fields latched.
- `wr` in 1: 1 = write burst, 0 = read burst.
- `addr` in AW: burst start address.
- `len` in AW: beat count minus 1 (0 → 1 beat, 511 → 512 beats).
- `wdata` in DW: write beat data.
- `wdata_valid` in 1: write data available.
- `wdata_ready` out 1: combinational, = (state == RUN) & wr_latched.
- `rdata` out DW: read beat data.
- `rvalid` out 1: one cycle per read beat; no backpressure.
- `rerr` out 1: sticky; RAM output enables were not all ones on a captured beat; cleared by `ack`.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse at burst completion.
- `ram_cen` out 1: RAM chip enable, active low.
- `ram_rw` out 1: 1 = read.
- `ram_a` out AW: RAM address.
- `ram_z_out` out DW: write data to RAM.
- `ram_z_oe` out DW: drive enables toward RAM data pins.
- `ram_z_in` in DW: RAM read data.
- `ram_z_oe_in` in DW: RAM output enables.

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE → RUN on `req`=1:
  - pulse `ack`;
  - latch `wr`, `addr`, `len`; beat counter := `len`;
  - clear `rerr`.
- RUN, read burst: issue one beat every cycle. The issue edge registers `ram_cen`=0, `ram_rw`=1, `ram_a`=current address, `ram_z_oe`=0000.
- RUN, write burst: issue a beat only on an edge where `wdata_valid & wdata_ready`. That edge registers `ram_cen`=0, `ram_rw`=0, `ram_a`, `ram_z_out`=`wdata`, `ram_z_oe`=FFFF. Otherwise register `ram_cen`=1 and `ram_z_oe`=0000.
- After each beat: address increments modulo 512 (511 → 0 wraps, not an error); counter decrements.
- Last beat issued (counter was 0) → DRAIN.
- DRAIN: exactly 2 cycles. Registers `ram_cen`=1, `ram_rw`=1, `ram_z_oe`=0000. Then → IDLE with `done`=1 registered on that edge.
- Read capture: a 2-stage issue-tracking shift register marks the edge two cycles after each read issue edge. At that edge:
  - `rdata` := `ram_z_in`; `rvalid`=1;
  - if `ram_z_oe_in` != FFFF, set `rerr`.
- Host inputs other than `wdata`/`wdata_valid` are ignored outside IDLE. `req` held high across `done` starts a new burst on the first IDLE cycle.

## Timing
- Reset values: `ram_cen`=1, `ram_rw`=1, `ram_a`=0, `ram_z_out`=0, `ram_z_oe`=0000, `ack`=0, `busy`=0, `done`=0, `rvalid`=0, `rdata`=0, `rerr`=0. `wdata_ready`=0 follows from IDLE.
- Reset mid-burst: immediate return to the values above, including any pending read captures. No `done` is produced.
- `req`=1 at edge E0 → `ack`=1 during E0..E1, RUN from E0. First read beat: `ram_cen` low after E1.
- Read latency: issue edge E → RAM samples at E+1 → `rvalid`/`rdata` after E+2.
- Read burst of N beats: `ram_cen` low for N consecutive cycles. The last `rvalid` coincides with `done`. `done` asserts N+2 cycles after RUN is entered.
- Write: the RAM samples the beat one edge after the issue edge. `done` follows the last issue edge by 2 cycles.

## Structure
- Shared package: state enum (IDLE/RUN/DRAIN), `OE_ALL` = 16'hFFFF, `OE_NONE` = 16'h0000, RAM geometry constants (512 words, 9-bit address).
- Single module. Read-capture pipe may be split into sub-module `ram16_rd_capture`: issue-tracking shift register, data/valid registers, `rerr` flag.
- Bench pairs the block with the existing 512×16 RAM model.

## Test plan
- Write burst `addr`=0x010, `len`=3, `wdata` 0xA001..0xA004 always valid → `ram_cen` low 4 consecutive cycles at 0x010..0x013 with `ram_z_oe`=FFFF; `done` 2 cycles after the last beat.
- Read back `addr`=0x010, `len`=3 → `rvalid` on 4 consecutive cycles with 0xA001..0xA004; first `rvalid` 3 cycles after the `ack` edge; `done` on the same cycle as the last `rvalid`; `rerr`=0.
- Wrap-around: write `addr`=0x1FE, `len`=2 → addresses 0x1FE, 0x1FF, 0x000; read back returns the same data.
- Write stall: `wdata_valid` deasserted for 3 cycles mid-burst → `ram_cen` high exactly those cycles; no skipped or duplicated addresses.
- Reset asserted during beat 2 of a read with `len`=7 → all outputs at reset values immediately; no further `rvalid`; next request behaves normally.
- Forced `ram_z_oe_in`=0000 during a read → `rerr`=1 stays set until the next `ack`.
